// File: rtl/kpyd_saw_pkg.sv
// Shared constants for the keypad sawtooth voice: note table, phase increments
// and the keypad row/column to hex-code map.
package kpyd_saw_pkg;

   localparam int unsigned SAMPLE_RATE   = 48000;
   localparam int unsigned PKG_ACC_WIDTH = 32;

   typedef logic [3:0] hex_t;

   localparam int unsigned NOTE_HZ [16] = '{
      261, 294, 330, 349, 392, 440, 494, 523,
      587, 659, 698, 784, 880, 988, 1046, 1174
   };

   // Indexed by {row, col}; col 0 is the leftmost keypad column.
   localparam hex_t KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   function automatic logic [31:0] calc_inc(input int unsigned freq_hz);
      logic [63:0] num_s;
      num_s = 64'(freq_hz) << PKG_ACC_WIDTH;
      return 32'(num_s / 64'(SAMPLE_RATE));
   endfunction

   // Evaluated at elaboration, so the datapath only sees a constant lookup.
   localparam logic [31:0] PHASE_INC_TAB [16] = '{
      calc_inc(NOTE_HZ[0]),  calc_inc(NOTE_HZ[1]),  calc_inc(NOTE_HZ[2]),  calc_inc(NOTE_HZ[3]),
      calc_inc(NOTE_HZ[4]),  calc_inc(NOTE_HZ[5]),  calc_inc(NOTE_HZ[6]),  calc_inc(NOTE_HZ[7]),
      calc_inc(NOTE_HZ[8]),  calc_inc(NOTE_HZ[9]),  calc_inc(NOTE_HZ[10]), calc_inc(NOTE_HZ[11]),
      calc_inc(NOTE_HZ[12]), calc_inc(NOTE_HZ[13]), calc_inc(NOTE_HZ[14]), calc_inc(NOTE_HZ[15])
   };

   function automatic logic [31:0] phase_inc(input hex_t hex);
      return PHASE_INC_TAB[hex];
   endfunction

   function automatic hex_t key_code(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col}];
   endfunction

endpackage

// File: rtl/kpyd_scan_decode.sv
// Keypad column scanner and decoder: divider, active-low column rotation,
// single-key decode to hex_o and the per-scan key_down_o flag.
module kpyd_scan_decode
   import kpyd_saw_pkg::*;
#(
   parameter int SCAN_DIV = 1024
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [3:0] kpyd_row_i,
   output logic [3:0] kpyd_col_o,
   output logic [3:0] hex_o,
   output logic       key_down_o
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_r;
   logic [3:0]       col_sel_r;
   hex_t             hex_r;
   logic             seen_r;
   logic             key_down_r;

   logic [3:0] pressed_s;
   logic       step_s;
   logic       press_s;
   logic [1:0] row_idx_s;
   logic [1:0] col_idx_s;

   assign pressed_s = ~kpyd_row_i;
   assign step_s    = (div_r == DIV_LAST);

   // Row decode: only a single pressed row counts as a key.
   always_comb begin
      row_idx_s = 2'd0;
      press_s   = 1'b0;
      case (pressed_s)
         4'b0001: begin row_idx_s = 2'd0; press_s = 1'b1; end
         4'b0010: begin row_idx_s = 2'd1; press_s = 1'b1; end
         4'b0100: begin row_idx_s = 2'd2; press_s = 1'b1; end
         4'b1000: begin row_idx_s = 2'd3; press_s = 1'b1; end
         default: begin row_idx_s = 2'd0; press_s = 1'b0; end
      endcase
   end

   // Column index of the currently driven column.
   always_comb begin
      col_idx_s = 2'd0;
      case (col_sel_r)
         4'b0001: col_idx_s = 2'd0;
         4'b0010: col_idx_s = 2'd1;
         4'b0100: col_idx_s = 2'd2;
         4'b1000: col_idx_s = 2'd3;
         default: col_idx_s = 2'd0;
      endcase
   end

   // Scan divider, column rotation, key latch and end-of-scan key_down update.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_r      <= '0;
         col_sel_r  <= 4'b0001;
         hex_r      <= 4'h0;
         seen_r     <= 1'b0;
         key_down_r <= 1'b0;
      end else begin
         div_r <= step_s ? '0 : div_r + DIV_W'(1);
         if (step_s) begin
            col_sel_r <= {col_sel_r[2:0], col_sel_r[3]};
         end
         if (press_s) begin
            hex_r <= key_code(row_idx_s, col_idx_s);
         end
         // Closing the scan takes priority over a press in that same cycle.
         if (step_s && (col_sel_r == 4'b1000)) begin
            key_down_r <= seen_r;
            seen_r     <= 1'b0;
         end else if (press_s) begin
            seen_r <= 1'b1;
         end
      end
   end

   assign kpyd_col_o = ~col_sel_r;
   assign hex_o      = hex_r;
   assign key_down_o = key_down_r;

endmodule

// File: rtl/kpyd_saw_voice.sv
// Single-voice keypad sawtooth synth: scanner/decoder, note-table phase
// accumulator and sawtooth output. Define KPYD_SAW_GATE_EN to mute when no key is down.
module kpyd_saw_voice
   import kpyd_saw_pkg::*;
#(
   parameter int SCAN_DIV   = 1024,
   parameter int ACC_WIDTH  = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int WIDTH      = 24
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [3:0]            kpyd_row_i,
   output logic [3:0]            kpyd_col_o,
   output logic [3:0]            hex_o,
   output logic                  key_down_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [WIDTH-1:0]      data_o,
   output logic                  valid_o
);

   hex_t                  hex_s;
   logic                  key_down_s;
   logic [ACC_WIDTH-1:0]  inc_s;
   logic [ACC_WIDTH-1:0]  acc_r;
   logic [ADDR_WIDTH-1:0] addr_s;
   logic [WIDTH-1:0]      saw_s;
   logic [WIDTH-1:0]      data_r;
   logic                  valid_r;

   kpyd_scan_decode #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .kpyd_row_i (kpyd_row_i),
      .kpyd_col_o (kpyd_col_o),
      .hex_o      (hex_s),
      .key_down_o (key_down_s)
   );

   assign inc_s  = ACC_WIDTH'(phase_inc(hex_s));
   assign addr_s = acc_r[ACC_WIDTH-1 -: ADDR_WIDTH];
   // addr - half-range as two's complement is just the inverted MSB.
   assign saw_s  = {~addr_s[ADDR_WIDTH-1], addr_s[ADDR_WIDTH-2:0], {(WIDTH-ADDR_WIDTH){1'b0}}};

   // Phase accumulator, sample register and valid flag.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_r   <= '0;
         data_r  <= {1'b1, {(WIDTH-1){1'b0}}};
         valid_r <= 1'b0;
      end else begin
         acc_r   <= acc_r + inc_s;
         valid_r <= 1'b1;
`ifdef KPYD_SAW_GATE_EN
         data_r  <= key_down_s ? saw_s : '0;
`else
         data_r  <= saw_s;
`endif
      end
   end

   assign hex_o      = hex_s;
   assign key_down_o = key_down_s;
   assign addr_o     = addr_s;
   assign data_o     = data_r;
   assign valid_o    = valid_r;

endmodule

// File: tb/tb_kpyd_saw_voice.sv
// Randomized keypad stimulus checked every cycle against a cycle-count based
// reference model of the keypad sawtooth voice.
module tb_kpyd_saw_voice;

   logic        clk;
   logic        reset;
   logic [3:0]  kpyd_row;
   logic [3:0]  kpyd_col;
   logic [3:0]  hex;
   logic        key_down;
   logic [8:0]  addr;
   logic [23:0] data;
   logic        valid;

   int total = 0;
   int bad   = 0;

   // keypad contents: up to two held keys
   int         key_n;
   logic [1:0] key_row [2];
   logic [1:0] key_col [2];

   // reference model state
   longint unsigned m_t;
   logic [3:0]      m_hex;
   bit              m_seen;
   bit              m_kd;
   longint unsigned m_acc;
   logic [23:0]     m_data;
   bit              m_valid;

   int unsigned tb_hz [16] = '{261, 294, 330, 349, 392, 440, 494, 523,
                               587, 659, 698, 784, 880, 988, 1046, 1174};
   logic [3:0] tb_key [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                 '{4'h4, 4'h5, 4'h6, 4'hB},
                                 '{4'h7, 4'h8, 4'h9, 4'hC},
                                 '{4'hE, 4'h0, 4'hF, 4'hD}};

   kpyd_saw_voice dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .kpyd_row_i (kpyd_row),
      .kpyd_col_o (kpyd_col),
      .hex_o      (hex),
      .key_down_o (key_down),
      .addr_o     (addr),
      .data_o     (data),
      .valid_o    (valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // physical keypad: a held key pulls its row low while its column is driven low
   always_comb begin
      kpyd_row = 4'hF;
      for (int k = 0; k < 2; k++) begin
         if (k < key_n && kpyd_col[key_col[k]] == 1'b0) kpyd_row[key_row[k]] = 1'b0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint unsigned ref_inc(input int idx);
      longint unsigned f;
      f = tb_hz[idx];
      return (f * 64'd4294967296) / 64'd48000;
   endfunction

   task automatic model_step();
      int              col;
      bit              step;
      logic [3:0]      rows;
      int              row;
      bit              press;
      logic [3:0]      n_hex;
      bit              n_seen, n_kd;
      longint signed   saw;
      if (reset) begin
         m_t = 0; m_hex = 4'h0; m_seen = 0; m_kd = 0;
         m_acc = 0; m_data = 24'h800000; m_valid = 0;
      end else begin
         col  = int'((m_t / 1024) % 4);
         step = ((m_t % 1024) == 1023);
         rows = 4'h0;
         row  = 0;
         for (int k = 0; k < key_n; k++) begin
            if (int'(key_col[k]) == col) rows[key_row[k]] = 1'b1;
         end
         press = ($countones(rows) == 1);
         for (int r = 0; r < 4; r++) if (rows[r]) row = r;
         n_hex  = press ? tb_key[row][col] : m_hex;
         n_seen = m_seen;
         n_kd   = m_kd;
         if (step && col == 3) begin
            n_kd = m_seen; n_seen = 0;
         end else if (press) begin
            n_seen = 1;
         end
         saw = (longint'(m_acc >> 23) - 256) * 32768;
`ifdef KPYD_SAW_GATE_EN
         m_data = m_kd ? 24'(saw) : 24'h000000;
`else
         m_data = 24'(saw);
`endif
         m_acc   = (m_acc + ref_inc(int'(m_hex))) % 64'd4294967296;
         m_hex   = n_hex;
         m_seen  = n_seen;
         m_kd    = n_kd;
         m_valid = 1;
         m_t++;
      end
   endtask

   task automatic check_all();
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((m_t / 1024) % 4));
      check_val("col", 32'(kpyd_col), 32'(exp_col));
      check_val("hex", 32'(hex), 32'(m_hex));
      check_val("key_down", 32'(key_down), 32'(m_kd));
      check_val("addr", 32'(addr), 32'(m_acc >> 23));
      check_val("data", 32'(data), 32'(m_data));
      check_val("valid", 32'(valid), 32'(m_valid));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic set_key(input int n, input int r0, input int c0, input int r1, input int c1);
      key_n      = n;
      key_row[0] = 2'(r0); key_col[0] = 2'(c0);
      key_row[1] = 2'(r1); key_col[1] = 2'(c1);
   endtask

   initial begin
      reset = 1'b1;
      set_key(0, 0, 0, 0, 0);
      m_t = 0; m_hex = 4'h0; m_seen = 0; m_kd = 0;
      m_acc = 0; m_data = 24'h800000; m_valid = 0;
      @(negedge clk);
      run(3);
      check_val("rst_col", 32'(kpyd_col), 32'h0000000E);
      check_val("rst_data", 32'(data), 32'h00800000);
      check_val("rst_valid", 32'(valid), 32'h0);

      // first sample after release: idx0 increment gives addr 2
      reset = 1'b0;
      cycle();
      check_val("valid_rise", 32'(valid), 32'h1);
      check_val("first_addr", 32'(addr), 32'd2);
      cycle();
`ifndef KPYD_SAW_GATE_EN
      check_val("first_data", 32'(data), 32'h00810000);
`endif

      check_val("inc0", kpyd_saw_pkg::phase_inc(4'h0), 32'd23353884);
      check_val("inc5", kpyd_saw_pkg::phase_inc(4'h5), 32'd39370533);
      for (int i = 0; i < 16; i++)
         check_val("pkg_inc", kpyd_saw_pkg::phase_inc(4'(i)), 32'(ref_inc(i)));

      // idle scan: columns walk, key_down stays low
      run(4 * 1024 + 10);
      check_val("idle_kd", 32'(key_down), 32'h0);

      // row1 in column 1 -> key 5
      set_key(1, 1, 1, 0, 0);
      run(2 * 4096);
      check_val("hex5", 32'(hex), 32'h5);
      check_val("kd5", 32'(key_down), 32'h1);

      // row3 in column 3 -> key D
      set_key(1, 3, 3, 0, 0);
      run(4200);
      check_val("hexD", 32'(hex), 32'hD);

      // two rows in the same column: code must hold
      set_key(2, 0, 2, 2, 2);
      run(4200);
      check_val("multi_hold", 32'(hex), 32'hD);

      // random keypad activity with one mid-run reset
      for (int seg = 0; seg < 12; seg++) begin
         set_key(int'($urandom % 3), int'($urandom % 4), int'($urandom % 4),
                 int'($urandom % 4), int'($urandom % 4));
         if (seg == 6) begin
            reset = 1'b1;
            run(2);
            reset = 1'b0;
         end
         run(int'($urandom_range(300, 3000)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
